// File: rtl/dot_scan_ctrl_pkg.sv
// Shared definitions for the dot-matrix scan controller and its column decoder.
package dot_scan_ctrl_pkg;

    // Board defaults: column slot length and leading blanking in clock cycles.
    localparam int unsigned DefDiv   = 1024;
    localparam int unsigned DefBlank = 64;

    // Widest column count the shared all-off pattern covers.
    localparam int unsigned MaxCols = 64;

    // Column select with no column driven (selects are active-low).
    localparam logic [MaxCols-1:0] ColAllOff = '1;

    // Display phase within a column slot.
    typedef enum logic {
        PhBlank,
        PhActive
    } scan_phase_e;

    // Ceiling log2, never less than one bit so single-entry ranges still get a port.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dot_col_dec.sv
// Column index to active-low one-hot select, with a blanking override.
// Indices outside 0..COLS-1 select no column.
module dot_col_dec
    import dot_scan_ctrl_pkg::*;
#(
    parameter int unsigned COLS = 8,
    parameter int unsigned COLW = clog2(COLS)
) (
    input  logic [COLW-1:0] i_col,
    input  logic            i_blank,
    output logic [COLS-1:0] o_col_n
);

    // Drive the single selected column low unless blanking.
    always_comb begin
        o_col_n = ColAllOff[COLS-1:0];
        if (!i_blank) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (i_col == COLW'(c)) begin
                    o_col_n[c] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dot_scan_ctrl.sv
// Time-multiplexed dot-matrix scan controller: slot prescaler, column counter,
// inter-column blanking and a double-buffered column store with frame-aligned swap.
module dot_scan_ctrl
    import dot_scan_ctrl_pkg::*;
#(
    parameter  int unsigned COLS  = 8,
    parameter  int unsigned ROWS  = 8,
    parameter  int unsigned DIV   = DefDiv,
    parameter  int unsigned BLANK = DefBlank,
    localparam int unsigned COLW  = clog2(COLS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_wr_en,
    input  logic [COLW-1:0] i_wr_col,
    input  logic [ROWS-1:0] i_wr_data,
    input  logic            i_swap_req,
    output logic            o_swap_busy,
    output logic            o_swap_done,
    output logic            o_frame_start,
    output logic [COLS-1:0] o_col_n,
    output logic [ROWS-1:0] o_row
);

    localparam int unsigned      PW        = clog2(DIV);
    localparam logic [PW-1:0]    PrescLast = PW'(DIV - 1);
    localparam logic [COLW-1:0]  ColLast   = COLW'(COLS - 1);

    logic            r_run;
    logic [PW-1:0]   r_presc;
    logic [COLW-1:0] r_col;
    logic            r_fs;          // index of the buffer currently displayed
    logic            r_pending;
    logic            r_swap_done;
    logic [ROWS-1:0] r_buf [2][COLS];

    logic            w_boundary;
    logic            w_take_swap;
    logic            w_in_blank;
    logic            w_blank;
    scan_phase_e     w_phase;
    logic [ROWS-1:0] w_front_row;

    // Last cycle of the last column slot; the swap lands on this edge.
    assign w_boundary  = r_run && (r_presc == PrescLast) && (r_col == ColLast);
    assign w_take_swap = w_boundary && (r_pending || i_swap_req);

    // Leading part of every slot is blanked so the previous column's drivers settle.
    if (BLANK == 0) begin : g_no_blank
        assign w_in_blank = 1'b0;
    end else begin : g_blank
        assign w_in_blank = (r_presc < PW'(BLANK));
    end

    // Scan position: restart from column 0 whenever the scan is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run   <= 1'b0;
            r_presc <= '0;
            r_col   <= '0;
        end else begin
            r_run <= i_en;
            if (!i_en) begin
                r_presc <= '0;
                r_col   <= '0;
            end else if (r_run) begin
                if (r_presc == PrescLast) begin
                    r_presc <= '0;
                    r_col   <= (r_col == ColLast) ? '0 : r_col + 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    // Swap handshake: a request waits for the frame boundary; one at the boundary goes straight in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fs        <= 1'b0;
            r_pending   <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= w_take_swap;
            if (w_take_swap) begin
                r_fs      <= ~r_fs;
                r_pending <= 1'b0;
            end else if (i_swap_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    // CPU writes always target the back buffer; an out-of-range column matches no entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    r_buf[b][c] <= '0;
                end
            end
        end else begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (i_wr_en && (i_wr_col == COLW'(c))) begin
                    r_buf[~r_fs][c] <= i_wr_data;
                end
            end
        end
    end

    // Phase of the current cycle within the slot.
    always_comb begin
        w_phase = (!r_run || w_in_blank) ? PhBlank : PhActive;
    end

    assign w_blank = (w_phase == PhBlank);

    // Row pattern of the selected column from the front buffer.
    always_comb begin
        w_front_row = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (r_col == COLW'(c)) begin
                w_front_row = r_buf[r_fs][c];
            end
        end
    end

    dot_col_dec #(
        .COLS (COLS),
        .COLW (COLW)
    ) u_col_dec (
        .i_col   (r_col),
        .i_blank (w_blank),
        .o_col_n (o_col_n)
    );

    assign o_row         = w_blank ? '0 : w_front_row;
    assign o_frame_start = r_run && (r_presc == '0) && (r_col == '0);
    assign o_swap_busy   = r_pending;
    assign o_swap_done   = r_swap_done;

endmodule
